// File: rtl/mux_lfsr_pkg.sv
// Shared defaults for the muxed Galois LFSR: width, x^3+x^2+1 toggle mask, reset seed.
// Pure constants and types; no logic, so no latency and no backpressure.
package mux_lfsr_pkg;

    localparam int DEF_WIDTH = 3;

    typedef logic [DEF_WIDTH-1:0] state_t;

    localparam state_t DEF_TAP_MASK   = 3'b110;
    localparam state_t DEF_RESET_SEED = 3'b001;

endpackage

// File: rtl/lfsr_mux_cell.sv
// One LFSR state bit: 2:1 mux (seed vs feedback) into a flop, one-cycle latency.
// No backpressure: captures on every edge; async active-high reset to its seed bit.
module lfsr_mux_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic arst,
    input  logic i_load_bit,
    input  logic i_fb_bit,
    input  logic i_l,
    output logic o_q
);

    logic w_d;
    logic r_q;

    assign w_d = i_l ? i_load_bit : i_fb_bit;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= w_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mux_lfsr.sv
// Muxed Galois LFSR: state exposed directly on LFSR, one-cycle load/step latency.
// No backpressure: the register updates on every non-reset edge.
module mux_lfsr
    import mux_lfsr_pkg::*;
#(
    parameter int                 WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0]   TAP_MASK   = DEF_TAP_MASK,
    parameter logic [WIDTH-1:0]   RESET_SEED = DEF_RESET_SEED
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [WIDTH-1:0] r,
    input  logic             L,
    output logic [WIDTH-1:0] LFSR
);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("mux_lfsr: WIDTH must be >= 2");
        end
        if (RESET_SEED == '0) begin : g_bad_seed
            $error("mux_lfsr: RESET_SEED must be non-zero");
        end
    endgenerate

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_fb;
    logic             w_zero;

    assign w_shift = {1'b0, w_q[WIDTH-1:1]} ^ (w_q[0] ? TAP_MASK : '0);
    assign w_zero  = (w_q == '0);

    // All-zero is a lock-up state for any XOR LFSR; kick back to the seed.
    assign w_fb = w_zero ? RESET_SEED : w_shift;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            lfsr_mux_cell #(
                .RST_VAL (RESET_SEED[gi])
            ) u_cell (
                .clk        (clk),
                .arst       (arst),
                .i_load_bit (r[gi]),
                .i_fb_bit   (w_fb[gi]),
                .i_l        (L),
                .o_q        (w_q[gi])
            );
        end
    endgenerate

    assign LFSR = w_q;

endmodule

// File: tb/tb_mux_lfsr.sv
// Directed bench for mux_lfsr with default parameters (3-bit, x^3+x^2+1, seed 001).
module tb_mux_lfsr;

    logic       clk;
    logic       arst;
    logic [2:0] r;
    logic       L;
    logic [2:0] LFSR;

    int checks;
    int failures;

    mux_lfsr dut (
        .clk  (clk),
        .arst (arst),
        .r    (r),
        .L    (L),
        .LFSR (LFSR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_and_sample;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        #2;
        arst = 1'b1;
        #1;
        checks++;
        if (LFSR !== 3'b001) begin
            failures++;
            $display("FAIL reset_async: got %b want 001", LFSR);
        end
        for (int i = 0; i < 3; i++) begin
            step_and_sample();
            checks++;
            if (LFSR !== 3'b001) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got %b want 001", i, LFSR);
            end
        end
    endtask

    task automatic test_free_run;
        logic [2:0] exp_seq [7];
        logic [2:0] seen [7];
        int dups;
        exp_seq = '{3'b110, 3'b011, 3'b111, 3'b101, 3'b100, 3'b010, 3'b001};
        arst = 1'b0;
        L    = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step_and_sample();
            seen[i] = LFSR;
            checks++;
            if (LFSR !== exp_seq[i]) begin
                failures++;
                $display("FAIL free_run[%0d]: got %b want %b", i, LFSR, exp_seq[i]);
            end
        end
        dups = 0;
        for (int i = 0; i < 7; i++)
            for (int j = i + 1; j < 7; j++)
                if (seen[i] === seen[j]) dups++;
        checks++;
        if (dups !== 0) begin
            failures++;
            $display("FAIL period_unique: got %0d repeats want 0", dups);
        end
    endtask

    task automatic test_load;
        logic [2:0] exp_after [2];
        exp_after = '{3'b101, 3'b100};
        L = 1'b0;
        for (int i = 0; i < 5; i++) step_and_sample();
        checks++;
        if (LFSR !== 3'b100) begin
            failures++;
            $display("FAIL load_pre: got %b want 100", LFSR);
        end
        L = 1'b1;
        r = 3'b111;
        step_and_sample();
        checks++;
        if (LFSR !== 3'b111) begin
            failures++;
            $display("FAIL load_111: got %b want 111", LFSR);
        end
        L = 1'b0;
        r = 3'b000;
        for (int i = 0; i < 2; i++) begin
            step_and_sample();
            checks++;
            if (LFSR !== exp_after[i]) begin
                failures++;
                $display("FAIL load_after[%0d]: got %b want %b", i, LFSR, exp_after[i]);
            end
        end
    endtask

    task automatic test_zero_load;
        L = 1'b1;
        r = 3'b000;
        step_and_sample();
        checks++;
        if (LFSR !== 3'b000) begin
            failures++;
            $display("FAIL zero_load: got %b want 000", LFSR);
        end
        L = 1'b0;
        r = 3'b111;
        step_and_sample();
        checks++;
        if (LFSR !== 3'b001) begin
            failures++;
            $display("FAIL zero_escape: got %b want 001", LFSR);
        end
        step_and_sample();
        checks++;
        if (LFSR !== 3'b110) begin
            failures++;
            $display("FAIL zero_resume: got %b want 110", LFSR);
        end
    endtask

    task automatic test_sustained_load;
        logic [2:0] vals [3];
        vals = '{3'b011, 3'b101, 3'b010};
        L = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r = vals[i];
            step_and_sample();
            checks++;
            if (LFSR !== vals[i]) begin
                failures++;
                $display("FAIL sustained[%0d]: got %b want %b", i, LFSR, vals[i]);
            end
        end
    endtask

    task automatic test_reset_priority;
        L    = 1'b1;
        r    = 3'b111;
        #2;
        arst = 1'b1;
        #1;
        checks++;
        if (LFSR !== 3'b001) begin
            failures++;
            $display("FAIL prio_async: got %b want 001", LFSR);
        end
        step_and_sample();
        checks++;
        if (LFSR !== 3'b001) begin
            failures++;
            $display("FAIL prio_hold: got %b want 001", LFSR);
        end
        arst = 1'b0;
        step_and_sample();
        checks++;
        if (LFSR !== 3'b111) begin
            failures++;
            $display("FAIL prio_release_load: got %b want 111", LFSR);
        end
        L = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        arst     = 1'b0;
        L        = 1'b0;
        r        = 3'b000;
        test_reset();
        test_free_run();
        test_load();
        test_zero_load();
        test_sustained_load();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_lfsr.md
Name: mux_lfsr

Overview:
- Muxed Galois LFSR: a WIDTH-bit (default 3) pseudo-random sequence generator.
- Each state bit is driven through a 2:1 mux that selects either the parallel-load seed or the Galois feedback next-state.
- Used as a small maximal-length pattern source or scrambler stage; its state is exposed directly as the output.

Parameters:
- WIDTH, 3, state/output width in bits (must be >= 2).
- TAP_MASK, 3'b110, Galois toggle mask XORed into the shifted state when the outgoing LSB is 1. The default implements x^3+x^2+1, a maximal period-7 polynomial.
- RESET_SEED, 3'b001, state loaded on reset (must be non-zero).

Ports:
- clk  input  1  rising-edge clock.
- arst  input  1  asynchronous reset, active-high. Forces the state to RESET_SEED immediately, independent of clk.
- r  input  WIDTH  parallel-load seed value.
- L  input  1  load select. 1 = load r on the next rising edge; 0 = advance the LFSR.
- LFSR  output  WIDTH  current register state (registered; no combinational path from inputs).

Behaviour:
- Single register q[WIDTH-1:0]; LFSR = q.
- Reset:
  - arst=1 -> q = RESET_SEED asynchronously; q holds while arst stays high, regardless of clk, L or r.
  - Release is synchronous in effect: the first update happens on the first rising edge with arst=0.
- Each rising clk edge with arst=0:
  - L=1 -> q <= r. One-cycle latency: the value appears on LFSR right after that edge.
  - L=0 and q != 0 -> q <= (q >> 1) ^ (q[0] ? TAP_MASK : 0).
  - Default bitwise form: next[2]=q[0], next[1]=q[2]^q[0], next[0]=q[1].
- Default sequence from 001 (period 7, all non-zero states): 001 -> 110 -> 011 -> 111 -> 101 -> 100 -> 010 -> 001.
- Lock-up escape: L=0 and q==0 -> q <= RESET_SEED, so the all-zero state lasts at most one cycle.
- Loading r=0 is allowed. LFSR shows 000 for one cycle, then escapes to RESET_SEED if L=0.
- Holding L high keeps reloading r on every edge; the state tracks r with one-cycle delay.
- No enable. The register updates on every non-reset edge.
- Reset mid-operation overrides any pending load or shift immediately.

Decomposition:
- Shared package: default WIDTH, TAP_MASK and RESET_SEED constants, plus a width-parameterised state typedef.
- Natural sub-module: lfsr_mux_cell, one bit instantiated WIDTH times via generate.
  - Inputs: load bit, feedback bit, L.
  - Function: 2:1 mux feeding a flop with async active-high reset to its RESET_SEED bit.
- Top level computes the feedback vector and the zero-escape logic.

Test Plan:
- Reset: assert arst mid-cycle with no clock edge -> LFSR=001 immediately. Holding arst high across several edges keeps LFSR=001.
- Free-run: release reset, L=0, 7 edges -> LFSR steps 110, 011, 111, 101, 100, 010, 001. Period exactly 7 with no repeats inside the period.
- Load: after 5 free-run edges (LFSR=100), set L=1, r=111 for one edge -> LFSR=111. Then L=0 -> 101, 100 on the following edges.
- Zero load: L=1, r=000 for one edge -> LFSR=000. Next edge with L=0 -> LFSR=001, then 110.
- Sustained load: L=1 while r changes 011 -> 101 -> 010 on successive cycles -> LFSR follows each value one edge later.
- Reset priority: assert arst in the same cycle L=1, r=111 -> LFSR=001 and no load takes effect. After release, the first edge with L=1 loads 111.
